// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window pipeline (window generator, bilateral, Sobel).
// Holds the default image geometry and the window slot map. Slot k = 3*row + col,
// where row 0 is the top row, col 0 is the left column, and slot 8 is the newest pixel.
package window_gen_3x3_pkg;

    localparam int unsigned WG_PIXEL_WIDTH = 8;
    localparam int unsigned WG_IMG_WIDTH   = 640;
    localparam int unsigned WG_IMG_HEIGHT  = 480;
    localparam int unsigned WG_X_BITS      = 10;
    localparam int unsigned WG_Y_BITS      = 9;

    localparam int unsigned WIN_SLOTS = 9;

    localparam int unsigned SLOT_TL = 0;
    localparam int unsigned SLOT_TC = 1;
    localparam int unsigned SLOT_TR = 2;
    localparam int unsigned SLOT_ML = 3;
    localparam int unsigned SLOT_C  = 4;
    localparam int unsigned SLOT_MR = 5;
    localparam int unsigned SLOT_BL = 6;
    localparam int unsigned SLOT_BC = 7;
    localparam int unsigned SLOT_BR = 8;

    // Slot index of window position (row, col).
    function automatic int unsigned win_slot(input int unsigned row, input int unsigned col);
        return 3 * row + col;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer_ram.sv
// line_buffer_ram: one-line pixel store with a synchronous, registered read.
// A read and a write to the same address in the same cycle return the old contents.
// Ports:
//   clk              clock
//   rd_en, rd_addr   read request; rd_data is valid the cycle after and holds otherwise
//   wr_en, wr_addr   write request with wr_data
// Contents are never reset.
module line_buffer_ram #(
    parameter int unsigned DEPTH     = 640,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read and write in the same process: the read samples pre-write contents.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator for raster-order grey pixels.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pixel_valid            pixel_data is valid this cycle
//   pixel_data             grey pixel
//   sof                    with pixel_valid, this pixel is (0,0)
//   window_valid           one-cycle pulse per emitted window
//   window_flat            9 slots, slot k at [PIXEL_WIDTH*k +: PIXEL_WIDTH]
//   center_x, center_y     window centre coordinates
//   frame_done             one-cycle pulse after the last pixel of a frame is accepted
// A window is emitted 2 cycles after each accepted pixel with x>=2 and y>=2.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = WG_PIXEL_WIDTH,
    parameter int unsigned IMG_WIDTH   = WG_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT  = WG_IMG_HEIGHT,
    parameter int unsigned X_BITS      = WG_X_BITS,
    parameter int unsigned Y_BITS      = WG_Y_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]         pixel_data,
    input  logic                           sof,
    output logic                           window_valid,
    output logic [PIXEL_WIDTH*WIN_SLOTS-1:0] window_flat,
    output logic [X_BITS-1:0]              center_x,
    output logic [Y_BITS-1:0]              center_y,
    output logic                           frame_done
);

    localparam int unsigned FLAT_W = PIXEL_WIDTH * WIN_SLOTS;

    logic [X_BITS-1:0]      x_cnt;
    logic [Y_BITS-1:0]      y_cnt;
    logic [X_BITS-1:0]      cur_x_c;
    logic [Y_BITS-1:0]      cur_y_c;
    logic                   last_col_c;
    logic                   last_row_c;

    logic                   s1_valid;
    logic [PIXEL_WIDTH-1:0] s1_pixel;
    logic [X_BITS-1:0]      s1_x;
    logic [Y_BITS-1:0]      s1_y;

    logic [PIXEL_WIDTH-1:0] line1_rd;
    logic [PIXEL_WIDTH-1:0] line0_rd;

    logic [FLAT_W-1:0]      win_q;
    logic [FLAT_W-1:0]      win_next_c;
    logic                   emit_c;

    // Coordinate of the pixel on the input this cycle; sof forces (0,0).
    always_comb begin
        cur_x_c    = sof ? '0 : x_cnt;
        cur_y_c    = sof ? '0 : y_cnt;
        last_col_c = (cur_x_c == X_BITS'(IMG_WIDTH - 1));
        last_row_c = (cur_y_c == Y_BITS'(IMG_HEIGHT - 1));
    end

    // Raster counters and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pixel_valid && last_col_c && last_row_c;
            if (pixel_valid) begin
                if (last_col_c) begin
                    x_cnt <= '0;
                    y_cnt <= last_row_c ? '0 : cur_y_c + Y_BITS'(1);
                end else begin
                    x_cnt <= cur_x_c + X_BITS'(1);
                    y_cnt <= cur_y_c;
                end
            end
        end
    end

    // line1 holds the previous row: read the old pixel above and replace it with the new one.
    line_buffer_ram #(
        .DEPTH     (IMG_WIDTH),
        .WIDTH     (PIXEL_WIDTH),
        .ADDR_BITS (X_BITS)
    ) u_line1 (
        .clk     (clk),
        .rd_en   (pixel_valid),
        .rd_addr (cur_x_c),
        .rd_data (line1_rd),
        .wr_en   (pixel_valid),
        .wr_addr (cur_x_c),
        .wr_data (pixel_data)
    );

    // line0 holds the row before that. Its write of the old line1 value lands one
    // cycle late, when that value emerges from line1; the same column is not read
    // again until the next row.
    line_buffer_ram #(
        .DEPTH     (IMG_WIDTH),
        .WIDTH     (PIXEL_WIDTH),
        .ADDR_BITS (X_BITS)
    ) u_line0 (
        .clk     (clk),
        .rd_en   (pixel_valid),
        .rd_addr (cur_x_c),
        .rd_data (line0_rd),
        .wr_en   (s1_valid),
        .wr_addr (s1_x),
        .wr_data (line1_rd)
    );

    // S1: capture the accepted pixel alongside the RAM reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= pixel_valid;
            if (pixel_valid) begin
                s1_pixel <= pixel_data;
                s1_x     <= cur_x_c;
                s1_y     <= cur_y_c;
            end
        end
    end

    // Window after shifting in the new column {line0_rd, line1_rd, s1_pixel}.
    always_comb begin
        win_next_c = win_q;
        for (int unsigned r = 0; r < 3; r++) begin
            win_next_c[PIXEL_WIDTH*win_slot(r, 0) +: PIXEL_WIDTH] =
                win_q[PIXEL_WIDTH*win_slot(r, 1) +: PIXEL_WIDTH];
            win_next_c[PIXEL_WIDTH*win_slot(r, 1) +: PIXEL_WIDTH] =
                win_q[PIXEL_WIDTH*win_slot(r, 2) +: PIXEL_WIDTH];
        end
        win_next_c[PIXEL_WIDTH*SLOT_TR +: PIXEL_WIDTH] = line0_rd;
        win_next_c[PIXEL_WIDTH*SLOT_MR +: PIXEL_WIDTH] = line1_rd;
        win_next_c[PIXEL_WIDTH*SLOT_BR +: PIXEL_WIDTH] = s1_pixel;
        emit_c = s1_valid && (s1_x >= X_BITS'(2)) && (s1_y >= Y_BITS'(2));
    end

    // S2: shift registers plus output registers, updated only for complete windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= '0;
            window_valid <= 1'b0;
            window_flat  <= '0;
            center_x     <= '0;
            center_y     <= '0;
        end else begin
            window_valid <= emit_c;
            if (s1_valid) begin
                win_q <= win_next_c;
            end
            if (emit_c) begin
                window_flat <= win_next_c;
                center_x    <= s1_x - X_BITS'(1);
                center_y    <= s1_y - Y_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 image.
module tb_window_gen_3x3;

    localparam int unsigned PW = 8;
    localparam int unsigned W  = 5;
    localparam int unsigned H  = 4;
    localparam int unsigned XB = 3;
    localparam int unsigned YB = 2;
    localparam int unsigned FW = PW * 9;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          pixel_valid = 1'b0;
    logic [PW-1:0] pixel_data  = '0;
    logic          sof         = 1'b0;
    logic          window_valid;
    logic [FW-1:0] window_flat;
    logic [XB-1:0] center_x;
    logic [YB-1:0] center_y;
    logic          frame_done;

    window_gen_3x3 #(
        .PIXEL_WIDTH (PW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .X_BITS      (XB),
        .Y_BITS      (YB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .sof          (sof),
        .window_valid (window_valid),
        .window_flat  (window_flat),
        .center_x     (center_x),
        .center_y     (center_y),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0] flat;
        int unsigned   cx;
        int unsigned   cy;
        int unsigned   due;
    } win_t;

    win_t        exp_q[$];
    int unsigned done_q[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    // Reference frame and raster position of the next pixel.
    logic [PW-1:0] img [H][W];
    int unsigned   mx = 0;
    int unsigned   my = 0;

    // Monitor bookkeeping.
    int unsigned   win_cnt  = 0;
    int unsigned   done_cnt = 0;
    int unsigned   cap_idx  = 0;
    logic [FW-1:0] cap_flat = '0;
    int unsigned   cap_x    = 0;
    int unsigned   cap_y    = 0;

    function automatic void check_val(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    function automatic void check_flat(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    // Record an accepted pixel in the reference frame and queue its expected outputs.
    function automatic void model_accept(input logic [PW-1:0] p, input bit s);
        win_t e;
        if (s) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = p;
        if (mx >= 2 && my >= 2) begin
            e.flat = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.flat[PW*(3*r+c) +: PW] = img[my-2+r][mx-2+c];
                end
            end
            e.cx  = mx - 1;
            e.cy  = my - 1;
            e.due = cyc + 2;
            exp_q.push_back(e);
        end
        if (mx == W - 1 && my == H - 1) done_q.push_back(cyc + 1);
        if (mx == W - 1) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endfunction

    task automatic drive(input bit v, input logic [PW-1:0] p, input bit s, input bit r);
        @(posedge clk);
        #1;
        rst         = r;
        pixel_valid = v;
        sof         = s;
        pixel_data  = v ? p : 8'hEE;
        if (r) begin
            mx = 0;
            my = 0;
        end else if (v) begin
            model_accept(p, s);
        end
    endtask

    task automatic send_frame(input bit rnd, input logic [PW-1:0] base, input bit first_sof, input bit gaps);
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, '0, 1'b0, 1'b0);
                drive(1'b1, rnd ? PW'($urandom) : base + PW'(16 * y + x),
                      first_sof && x == 0 && y == 0, 1'b0);
            end
        end
    endtask

    task automatic drain(input string name);
        repeat (6) drive(1'b0, '0, 1'b0, 1'b0);
        check_val({name, "_windows_left"}, 32'(exp_q.size()), 0);
        check_val({name, "_done_left"}, 32'(done_q.size()), 0);
    endtask

    task automatic check_zero(input string name);
        check_val({name, "_valid"}, 32'(window_valid), 0);
        check_val({name, "_done"}, 32'(frame_done), 0);
        check_flat({name, "_flat"}, window_flat, '0);
        check_val({name, "_cx"}, 32'(center_x), 0);
        check_val({name, "_cy"}, 32'(center_y), 0);
    endtask

    // Scoreboard monitor: compare every presented window and frame_done pulse.
    always @(negedge clk) begin : monitor
        win_t        e;
        int unsigned d;
        if (window_valid) begin
            if (win_cnt == cap_idx) begin
                cap_flat = window_flat;
                cap_x    = 32'(center_x);
                cap_y    = 32'(center_y);
            end
            win_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL window_unexpected: got window at cycle %0d, required none", cyc);
            end else begin
                e = exp_q.pop_front();
                check_flat("win_flat", window_flat, e.flat);
                check_val("win_cx", 32'(center_x), e.cx);
                check_val("win_cy", 32'(center_y), e.cy);
                check_val("win_cycle", cyc, e.due);
            end
        end
        if (frame_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                checks++;
                $display("FAIL frame_done_unexpected: got pulse at cycle %0d, required none", cyc);
            end else begin
                d = done_q.pop_front();
                check_val("frame_done_cycle", cyc, d);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int unsigned w0;
        int unsigned d0;

        // Reset state.
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_zero("reset");

        // Continuous frame with sof; first window is hand-computed.
        w0 = win_cnt; d0 = done_cnt; cap_idx = win_cnt;
        send_frame(1'b0, 8'h00, 1'b1, 1'b0);
        drain("t1");
        check_flat("t1_first_flat", cap_flat, 72'h22_21_20_12_11_10_02_01_00);
        check_val("t1_first_cx", cap_x, 1);
        check_val("t1_first_cy", cap_y, 1);
        check_val("t1_windows", win_cnt - w0, 6);
        check_val("t1_done", done_cnt - d0, 1);

        // Same image with random gaps in pixel_valid.
        w0 = win_cnt; d0 = done_cnt; cap_idx = win_cnt;
        send_frame(1'b0, 8'h00, 1'b1, 1'b1);
        drain("t2");
        check_flat("t2_first_flat", cap_flat, 72'h22_21_20_12_11_10_02_01_00);
        check_val("t2_windows", win_cnt - w0, 6);
        check_val("t2_done", done_cnt - d0, 1);

        // Back-to-back frames, second offset by 0x80.
        w0 = win_cnt; d0 = done_cnt; cap_idx = win_cnt + 6;
        send_frame(1'b0, 8'h00, 1'b1, 1'b0);
        send_frame(1'b0, 8'h80, 1'b1, 1'b0);
        drain("t3");
        check_val("t3_f2_center_pix", 32'(cap_flat[PW*4 +: PW]), 32'h91);
        check_val("t3_f2_first_cx", cap_x, 1);
        check_val("t3_f2_first_cy", cap_y, 1);
        check_val("t3_windows", win_cnt - w0, 12);
        check_val("t3_done", done_cnt - d0, 2);

        // Frame aborted by sof at (3,2), then a full frame.
        w0 = win_cnt; d0 = done_cnt; cap_idx = win_cnt + 1;
        for (int i = 0; i < int'(2 * W + 3); i++) begin
            drive(1'b1, 8'h40 + PW'(16 * (i / int'(W)) + i % int'(W)), i == 0, 1'b0);
        end
        send_frame(1'b0, 8'hA0, 1'b1, 1'b0);
        drain("t4");
        check_val("t4_f2_center_pix", 32'(cap_flat[PW*4 +: PW]), 32'hB1);
        check_val("t4_windows", win_cnt - w0, 7);
        check_val("t4_done", done_cnt - d0, 1);

        // One-cycle reset at pixel (2,3), then a frame without sof.
        w0 = win_cnt; d0 = done_cnt;
        for (int i = 0; i < int'(3 * W + 2); i++) begin
            drive(1'b1, 8'h10 + PW'(16 * (i / int'(W)) + i % int'(W)), i == 0, 1'b0);
        end
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_zero("midrst");
        cap_idx = win_cnt;
        send_frame(1'b0, 8'h60, 1'b0, 1'b0);
        drain("t5");
        check_flat("t5_first_flat", cap_flat, 72'h82_81_80_72_71_70_62_61_60);
        check_val("t5_windows", win_cnt - w0, 9);
        check_val("t5_done", done_cnt - d0, 1);

        // Random pixel frames with gaps.
        w0 = win_cnt; d0 = done_cnt;
        send_frame(1'b1, 8'h00, 1'b1, 1'b1);
        send_frame(1'b1, 8'h00, 1'b0, 1'b1);
        drain("t6");
        check_val("t6_windows", win_cnt - w0, 12);
        check_val("t6_done", done_cnt - d0, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
